// File: rtl/wts_pkg.sv
// Shared widths and the scheduler state encoding for the wave memory scheduler.
package wts_pkg;

    localparam int WTS_WAVE_AW = 7;
    localparam int WTS_SRAM_AW = 10;
    localparam int WTS_DW      = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CH_SLOT  = 2'd1,
        ST_CPU_SLOT = 2'd2,
        ST_ACK      = 2'd3
    } wts_state_e;

endpackage

// File: rtl/wts_slot_sequencer.sv
// Round sequencer for the wave memory scheduler: state, slot counter, restart.
// Optional build macro WTS_CPU_IDLE_SLOT_EN lets a pending CPU request be
// served from IDLE without waiting for the next round.
//
// state       | meaning
// ------------+-------------------------------------------------------
// ST_IDLE     | no round in progress, SRAM strobes low
// ST_CH_SLOT  | channel read slot, slot_q selects the channel
// ST_CPU_SLOT | CPU slot, access issued when cpu_req is high
// ST_ACK      | cpu_ack cycle after a served CPU access
module wts_slot_sequencer
    import wts_pkg::*;
#(
    parameter int CH_NUM = 5
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       active,
    input  logic       cpu_req,
    output wts_state_e state_q,
    output logic [2:0] slot_q
);

    wts_state_e state_d;
    logic [2:0] slot_d;

    // Next-state: active always restarts a round, regardless of state.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (active) begin
            state_d = ST_CH_SLOT;
            slot_d  = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
`ifdef WTS_CPU_IDLE_SLOT_EN
                    if (cpu_req) begin
                        state_d = ST_CPU_SLOT;
                    end
`endif
                end
                ST_CH_SLOT: begin
                    if (slot_q == 3'(CH_NUM - 1)) begin
                        state_d = ST_CPU_SLOT;
                        slot_d  = 3'd0;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
                ST_CPU_SLOT: begin
                    state_d = cpu_req ? ST_ACK : ST_IDLE;
                end
                ST_ACK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    slot_d  = 3'd0;
                end
            endcase
        end
    end

    // State and slot registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            slot_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

endmodule

// File: rtl/wts_wave_memory_scheduler.sv
// Wave memory scheduler: time-shares one wave SRAM between CH_NUM channel
// readers and a CPU port. Each active pulse snapshots the channel addresses,
// reads one sample per channel, then offers one CPU slot.
// Build macro WTS_CPU_IDLE_SLOT_EN (in wts_slot_sequencer) also serves the
// CPU from IDLE cycles.
module wts_wave_memory_scheduler
    import wts_pkg::*;
#(
    parameter int CH_NUM = 5
) (
    input  logic                          clk,
    input  logic                          nreset,
    input  logic                          active,
    input  logic [WTS_WAVE_AW*CH_NUM-1:0] ch_sram_a,
    output logic [WTS_DW*CH_NUM-1:0]      wave_data,
    input  logic                          cpu_req,
    input  logic                          cpu_we,
    input  logic [WTS_SRAM_AW-1:0]        cpu_a,
    input  logic [WTS_DW-1:0]             cpu_d,
    output logic                          cpu_ack,
    output logic [WTS_DW-1:0]             cpu_q,
    output logic [WTS_SRAM_AW-1:0]        sram_a,
    output logic                          sram_oe,
    output logic                          sram_we,
    output logic [WTS_DW-1:0]             sram_d,
    input  logic [WTS_DW-1:0]             sram_q
);

    wts_state_e state_q;
    logic [2:0] slot_q;

    logic [WTS_WAVE_AW*CH_NUM-1:0] snap_q, snap_d;
    logic [WTS_DW*CH_NUM-1:0]      wave_data_q, wave_data_d;
    logic [WTS_SRAM_AW-1:0]        sram_a_q, sram_a_d;
    logic [WTS_DW-1:0]             sram_d_q, sram_d_d;
    logic [WTS_DW-1:0]             cpu_q_q, cpu_q_d;
    logic                          rd_vld_q, rd_vld_d;
    logic [2:0]                    rd_ch_q, rd_ch_d;
    logic                          cpu_ack_q, cpu_ack_d;
    logic                          cpu_rd_q, cpu_rd_d;
    logic [WTS_WAVE_AW-1:0]        ch_addr;
    logic                          issue_ch, issue_cpu;

    wts_slot_sequencer #(
        .CH_NUM (CH_NUM)
    ) u_seq (
        .clk     (clk),
        .nreset  (nreset),
        .active  (active),
        .cpu_req (cpu_req),
        .state_q (state_q),
        .slot_q  (slot_q)
    );

    assign issue_ch  = (state_q == ST_CH_SLOT);
    assign issue_cpu = (state_q == ST_CPU_SLOT) && cpu_req;

    // Pick the snapshot address of the channel owning the current slot.
    always_comb begin
        ch_addr = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (slot_q == 3'(i)) begin
                ch_addr = snap_q[i*WTS_WAVE_AW +: WTS_WAVE_AW];
            end
        end
    end

    // SRAM port: strobes follow the current slot directly from the state
    // register, so a CPU write happens only if cpu_req is high in that very
    // cycle; address and write data hold their last value between slots.
    always_comb begin
        sram_a_d = sram_a_q;
        sram_d_d = sram_d_q;
        sram_oe  = 1'b0;
        sram_we  = 1'b0;
        if (issue_ch) begin
            sram_a_d = {slot_q, ch_addr};
            sram_oe  = 1'b1;
        end else if (issue_cpu) begin
            sram_a_d = cpu_a;
            if (cpu_we) begin
                sram_we  = 1'b1;
                sram_d_d = cpu_d;
            end else begin
                sram_oe = 1'b1;
            end
        end
    end

    assign sram_a = sram_a_d;
    assign sram_d = sram_d_d;

    // Snapshot, read-return tracking and sample capture.
    always_comb begin
        snap_d      = active ? ch_sram_a : snap_q;
        rd_vld_d    = issue_ch;
        rd_ch_d     = slot_q;
        cpu_ack_d   = issue_cpu;
        cpu_rd_d    = issue_cpu && !cpu_we;
        wave_data_d = wave_data_q;
        if (rd_vld_q) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (rd_ch_q == 3'(i)) begin
                    wave_data_d[i*WTS_DW +: WTS_DW] = sram_q;
                end
            end
        end
    end

    // CPU read data is passed straight through in the ack cycle and held after.
    always_comb begin
        cpu_q_d = cpu_rd_q ? sram_q : cpu_q_q;
    end

    assign cpu_q     = cpu_q_d;
    assign cpu_ack   = cpu_ack_q;
    assign wave_data = wave_data_q;

    // Datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            snap_q      <= '0;
            wave_data_q <= '0;
            sram_a_q    <= '0;
            sram_d_q    <= '0;
            cpu_q_q     <= '0;
            rd_vld_q    <= 1'b0;
            rd_ch_q     <= 3'd0;
            cpu_ack_q   <= 1'b0;
            cpu_rd_q    <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            wave_data_q <= wave_data_d;
            sram_a_q    <= sram_a_d;
            sram_d_q    <= sram_d_d;
            cpu_q_q     <= cpu_q_d;
            rd_vld_q    <= rd_vld_d;
            rd_ch_q     <= rd_ch_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rd_q    <= cpu_rd_d;
        end
    end

endmodule

// File: tb/tb_wts_wave_memory_scheduler.sv
// Directed bench for wts_wave_memory_scheduler with a behavioural SRAM.
module tb_wts_wave_memory_scheduler;

    localparam int CH_NUM = 5;

    logic              clk;
    logic              nreset;
    logic              active;
    logic [7*CH_NUM-1:0] ch_sram_a;
    logic [8*CH_NUM-1:0] wave_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [9:0]        cpu_a;
    logic [7:0]        cpu_d;
    logic              cpu_ack;
    logic [7:0]        cpu_q;
    logic [9:0]        sram_a;
    logic              sram_oe;
    logic              sram_we;
    logic [7:0]        sram_d;
    logic [7:0]        sram_q;

    logic [7:0]        mem [1024];
    logic              pre_en;
    logic [9:0]        pre_a;
    logic [7:0]        pre_d;
    int                wr_cnt;
    int                ack_cnt;
    int                n_tests;
    int                n_fail;

    wts_wave_memory_scheduler #(.CH_NUM(CH_NUM)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .active    (active),
        .ch_sram_a (ch_sram_a),
        .wave_data (wave_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_a     (cpu_a),
        .cpu_d     (cpu_d),
        .cpu_ack   (cpu_ack),
        .cpu_q     (cpu_q),
        .sram_a    (sram_a),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_d    (sram_d),
        .sram_q    (sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read data one cycle after sram_oe; bench preload port.
    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        else if (sram_we) mem[sram_a] <= sram_d;
        if (sram_oe) sram_q <= mem[sram_a];
    end

    initial begin
        wr_cnt  = 0;
        ack_cnt = 0;
    end

    // Event counters for write strobes and acks.
    always @(posedge clk) begin
        if (sram_we) wr_cnt <= wr_cnt + 1;
        if (cpu_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_round();
        active = 1'b1;
        tick();
        active = 1'b0;
    endtask

    task automatic set_ch_addr(input logic [6:0] base);
        for (int n = 0; n < CH_NUM; n++) ch_sram_a[n*7 +: 7] = 7'(base + 7'(n));
    endtask

    logic [39:0] exp_w;
    logic [9:0]  exp_a [5];
    int          ack_base;
    int          wr_base;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        nreset  = 1'b0;
        active  = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        cpu_a   = '0;
        cpu_d   = '0;
        pre_en  = 1'b0;
        pre_a   = '0;
        pre_d   = '0;
        ch_sram_a = '0;
        exp_a[0] = 10'h010; exp_a[1] = 10'h091; exp_a[2] = 10'h112;
        exp_a[3] = 10'h193; exp_a[4] = 10'h214;

        // Preload wave samples while in reset.
        tick();
        for (int n = 0; n < CH_NUM; n++) begin
            pre_en = 1'b1; pre_a = exp_a[n]; pre_d = 8'(8'hA0 + n);
            tick();
            pre_en = 1'b1; pre_a = {3'(n), 7'(7'h20 + n)}; pre_d = 8'(8'hB0 + n);
            tick();
        end
        pre_en = 1'b0;
        tick();

        chk_eq("rst_sram_a", 64'(sram_a), 64'h0);
        chk_eq("rst_strobes", 64'({sram_oe, sram_we}), 64'h0);
        chk_eq("rst_sram_d", 64'(sram_d), 64'h0);
        chk_eq("rst_ack_q", 64'({cpu_ack, cpu_q}), 64'h0);
        chk_eq("rst_wave", 64'(wave_data), 64'h0);

        nreset = 1'b1;
        tick();

        // Basic round, no CPU request.
        set_ch_addr(7'h10);
        start_round();
        for (int k = 0; k < CH_NUM; k++) begin
            exp_w = '0;
            for (int n = 0; n < CH_NUM; n++)
                if (k >= n + 2) exp_w[n*8 +: 8] = 8'(8'hA0 + n);
            chk_eq($sformatf("slot%0d_a", k), 64'(sram_a), 64'(exp_a[k]));
            chk_eq($sformatf("slot%0d_oe_we", k), 64'({sram_oe, sram_we}), 64'b10);
            chk_eq($sformatf("slot%0d_wave", k), 64'(wave_data), 64'(exp_w));
            tick();
        end
        chk_eq("idle_cpu_slot_strobes", 64'({sram_oe, sram_we}), 64'h0);
        chk_eq("idle_cpu_slot_a_hold", 64'(sram_a), 64'h214);
        tick();
        chk_eq("no_req_ack", 64'(cpu_ack), 64'h0);
        chk_eq("wave_full", 64'(wave_data), 64'hA4A3A2A1A0);
        tick();
        chk_eq("no_req_ack2", 64'(cpu_ack), 64'h0);

        // CPU write then read of 0x155.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 10'h155; cpu_d = 8'h5A;
        start_round();
        tick_n(5);
        chk_eq("wr_strobes", 64'({sram_oe, sram_we}), 64'b01);
        chk_eq("wr_a", 64'(sram_a), 64'h155);
        chk_eq("wr_d", 64'(sram_d), 64'h5A);
        tick();
        chk_eq("wr_ack", 64'(cpu_ack), 64'h1);
        cpu_req = 1'b0;
        chk_eq("wr_mem", 64'(mem[10'h155]), 64'h5A);
        tick();
        chk_eq("wr_ack_end", 64'({cpu_ack, sram_we}), 64'h0);
        chk_eq("wr_a_hold", 64'(sram_a), 64'h155);

        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 10'h155;
        start_round();
        tick_n(5);
        chk_eq("rd_strobes", 64'({sram_oe, sram_we}), 64'b10);
        chk_eq("rd_a", 64'(sram_a), 64'h155);
        tick();
        chk_eq("rd_ack", 64'(cpu_ack), 64'h1);
        chk_eq("rd_q", 64'(cpu_q), 64'h5A);
        cpu_req = 1'b0;
        tick();
        chk_eq("rd_q_hold", 64'(cpu_q), 64'h5A);

        // Restart by a second active at t+3 with a pending write.
        ack_base = ack_cnt;
        wr_base  = wr_cnt;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 10'h0AA; cpu_d = 8'h33;
        start_round();
        tick_n(2);
        set_ch_addr(7'h20);
        start_round();
        chk_eq("restart_a", 64'(sram_a), 64'h020);
        chk_eq("restart_oe", 64'(sram_oe), 64'h1);
        tick_n(5);
        chk_eq("restart_wr", 64'({sram_we, sram_a}), 64'({1'b1, 10'h0AA}));
        chk_eq("restart_no_early_ack", 64'(ack_cnt - ack_base), 64'h0);
        tick();
        chk_eq("restart_ack", 64'(cpu_ack), 64'h1);
        cpu_req = 1'b0;
        tick();
        chk_eq("restart_wave", 64'(wave_data), 64'hB4B3B2B1B0);
        chk_eq("restart_ack_once", 64'(ack_cnt - ack_base), 64'h1);
        chk_eq("restart_wr_once", 64'(wr_cnt - wr_base), 64'h1);

        // Reset mid-round with a pending write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 10'h0F0; cpu_d = 8'h77;
        start_round();
        tick();
        nreset = 1'b0;
        tick();
        chk_eq("mrst_a", 64'(sram_a), 64'h0);
        chk_eq("mrst_strobes", 64'({sram_oe, sram_we}), 64'h0);
        chk_eq("mrst_d", 64'(sram_d), 64'h0);
        chk_eq("mrst_ack_q", 64'({cpu_ack, cpu_q}), 64'h0);
        chk_eq("mrst_wave", 64'(wave_data), 64'h0);
        nreset = 1'b1;
`ifdef WTS_CPU_IDLE_SLOT_EN
        tick();
        chk_eq("mrst_idle_wr", 64'({sram_we, sram_a}), 64'({1'b1, 10'h0F0}));
        tick();
        chk_eq("mrst_idle_ack", 64'(cpu_ack), 64'h1);
        cpu_req = 1'b0;
        tick();
        start_round();
        tick_n(6);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("mrst_idle_no_wr", 64'({sram_we, cpu_ack}), 64'h0);
        end
        start_round();
        tick_n(5);
        chk_eq("mrst_round_wr", 64'({sram_we, sram_a}), 64'({1'b1, 10'h0F0}));
        chk_eq("mrst_round_d", 64'(sram_d), 64'h77);
        tick();
        chk_eq("mrst_round_ack", 64'(cpu_ack), 64'h1);
        cpu_req = 1'b0;
`endif
        tick();
        chk_eq("mrst_round_wave", 64'(wave_data), 64'hB4B3B2B1B0);

        // CPU request raised while IDLE.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_a = 10'h155;
`ifdef WTS_CPU_IDLE_SLOT_EN
        tick();
        chk_eq("idle_rd_strobe", 64'({sram_oe, sram_a}), 64'({1'b1, 10'h155}));
        tick();
        chk_eq("idle_rd_ack", 64'({cpu_ack, cpu_q}), 64'({1'b1, 8'h5A}));
        cpu_req = 1'b0;
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 10'h300; cpu_d = 8'h11;
        start_round();
        chk_eq("idle_active_wins", 64'({sram_oe, sram_we, sram_a}), 64'({2'b10, 10'h020}));
        tick_n(5);
        chk_eq("idle_active_cpu_later", 64'({sram_we, sram_a}), 64'({1'b1, 10'h300}));
        tick();
        chk_eq("idle_active_ack", 64'(cpu_ack), 64'h1);
        cpu_req = 1'b0;
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq("idle_not_served", 64'({sram_oe, sram_we, cpu_ack}), 64'h0);
        end
        start_round();
        tick_n(5);
        chk_eq("idle_rd_in_slot", 64'({sram_oe, sram_a}), 64'({1'b1, 10'h155}));
        tick();
        chk_eq("idle_rd_ack", 64'({cpu_ack, cpu_q}), 64'({1'b1, 8'h5A}));
        cpu_req = 1'b0;
`endif
        tick_n(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wts_wave_memory_scheduler.md
WTS_WAVE_MEMORY_SCHEDULER -- requirements
Module: wts_wave_memory_scheduler

Interface
REQ-001 Parameter CH_NUM, default 5, number of channel parts sharing the wave SRAM (range 1..8).
REQ-002 clk  in  1  system clock; the only clock.
REQ-003 nreset  in  1  reset, synchronous, active-low (negative logic).
REQ-004 active  in  1  3.579MHz timing pulse, one clk wide; starts a scheduling round.
REQ-005 ch_sram_a  in  7*CH_NUM  per-channel wave address; channel n occupies bits [7n+6:7n].
REQ-006 wave_data  out  8*CH_NUM  per-channel latched wave sample; channel n occupies bits [8n+7:8n].
REQ-007 cpu_req  in  1  CPU access request, held high until cpu_ack.
REQ-008 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-009 cpu_a  in  10  CPU SRAM address; stable while cpu_req is high.
REQ-010 cpu_d  in  8  CPU write data.
REQ-011 cpu_ack  out  1  one-clk pulse, access complete.
REQ-012 cpu_q  out  8  CPU read data, valid from the cpu_ack cycle until the next read completes.
REQ-013 sram_a  out  10  shared SRAM address.
REQ-014 sram_oe  out  1  SRAM read strobe.
REQ-015 sram_we  out  1  SRAM write strobe.
REQ-016 sram_d  out  8  SRAM write data.
REQ-017 sram_q  in  8  SRAM read data; valid in the cycle after the cycle in which sram_oe is high.

Function
REQ-018 Cycle t is the cycle with active=1. In cycle t the block snapshots all ch_sram_a and loads slot counter = 0.
REQ-019 Slot k (0..CH_NUM-1) is issued in cycle t+1+k: sram_a={k[2:0],snapshot_a[k]}, sram_oe=1, sram_we=0.
REQ-020 sram_q of slot k is captured into wave_data channel k at the end of cycle t+2+k. The other channels hold their value.
REQ-021 CPU slot is issued in cycle t+1+CH_NUM. With cpu_req=1 the block drives sram_a=cpu_a and asserts sram_we (cpu_we=1, sram_d=cpu_d) or sram_oe (cpu_we=0). With cpu_req=0 all strobes are low.
REQ-022 cpu_ack pulses in the cycle after the CPU slot. For a read, cpu_q takes sram_q in that same cycle.
REQ-023 Outside issued slots, sram_oe=0, sram_we=0, and sram_a holds its last value.
REQ-024 States: IDLE, CH_SLOT, CPU_SLOT, ACK. Transitions: active goes IDLE->CH_SLOT; the last channel goes to CPU_SLOT; CPU_SLOT goes to ACK if a request was served, else to IDLE; ACK goes to IDLE.
REQ-025 An active pulse in any non-IDLE state restarts the round at slot 0 with a fresh snapshot. An unserved cpu_req stays pending, gets no ack, and loses no data.
REQ-026 A cpu_req deasserted without ack is a protocol violation. The behaviour is not defined beyond: no write occurs unless cpu_req=1 in the CPU slot cycle.
REQ-027 At most one CPU access per round. Each cpu_req is acked exactly once.
REQ-028 The system guarantees active period >= CH_NUM+3 clk. The block does not check this.

Reset
REQ-029 nreset=0 sampled at a clk edge forces: state IDLE, slot counter 0, sram_a=0, sram_oe=0, sram_we=0, sram_d=0, cpu_ack=0, cpu_q=0, all wave_data=0.
REQ-030 Reset mid-round abandons the round. A pending CPU request is re-served in the first full round after reset.

Configuration
REQ-031 Macro WTS_CPU_IDLE_SLOT_EN defined: a pending cpu_req is also served in any IDLE cycle, taking the CPU_SLOT->ACK path. An active pulse in that same cycle wins and the CPU waits.
REQ-032 Macro WTS_CPU_IDLE_SLOT_EN undefined: the CPU is served only in the CPU slot of a round.

Structure
REQ-033 Package wts_pkg holds: WTS_WAVE_AW=7, WTS_SRAM_AW=10, WTS_DW=8, and the state enumeration typedef.
REQ-034 One sub-module, wts_slot_sequencer: holds the state, the slot counter and the restart logic. The top level contains the snapshot registers, data capture and CPU port.

Verification
REQ-035 CH_NUM=5, ch n address=0x10+n, SRAM[{n,0x10+n}]=0xA0+n, single active pulse -> sram_a=0x010,0x091,0x112,0x193,0x214 in t+1..t+5; wave_data ch n=0xA0+n from t+3+n.
REQ-036 cpu_req=1, cpu_we=1, cpu_a=0x155, cpu_d=0x5A held before active -> sram_we=1 with sram_a=0x155 at t+6; cpu_ack at t+7; later CPU read of 0x155 returns cpu_q=0x5A.
REQ-037 Second active at t+3 -> slots restart at t+4 with the new snapshot; no cpu_ack before the completed round; the pending write is performed once.
REQ-038 nreset=0 at t+2 -> next cycle all outputs are 0; the following round completes normally.
REQ-039 Macro WTS_CPU_IDLE_SLOT_EN defined, cpu_req raised in IDLE, no active -> strobe next cycle, cpu_ack one cycle later; same cycle as active -> channel slot first, CPU served later.
REQ-040 cpu_req=0 for a whole round -> sram_oe and sram_we low in the CPU slot; cpu_ack never pulses.
